// File: rtl/bin_bbox_detect.sv
// bin_bbox_detect: measures the foreground bounding box (column/row bounds and
// pixel count) of each binary frame and publishes it once at frame end.
// The bit stream is forwarded with a one-clock delay.
// Optional feature macro: BBOX_OVERLAY_EN draws the last found box onto the
// forwarded bit stream.
//
// Handshake: there is no back-pressure. A pixel is accepted on every clock
// where per_frame_href & per_frame_clken are high; bbox_valid is a one-clock
// pulse and the result outputs hold until the next pulse.
module bin_bbox_detect #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int CNT_W   = 11,
  parameter int PIX_W   = 20,
  parameter int MIN_PIX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic             per_img_Bit,
  output logic             bbox_valid,
  output logic             box_found,
  output logic [CNT_W-1:0] x_min,
  output logic [CNT_W-1:0] x_max,
  output logic [CNT_W-1:0] y_min,
  output logic [CNT_W-1:0] y_max,
  output logic [PIX_W-1:0] pix_cnt,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic             post_img_Bit
);

  localparam logic [CNT_W-1:0] W_LIM   = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] H_LIM   = CNT_W'(IMG_H);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};
  localparam logic [PIX_W-1:0] MIN_L   = PIX_W'(MIN_PIX);

  typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             frame_start;
  logic             vsync_d;
  logic             href_d;
  logic             armed;
  logic             clken_d;
  logic             vsync_rise;
  logic             vsync_fall;
  logic             href_fall;
  logic             pix_valid;
  logic             fg;
  logic             found_now;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] x_lo;
  logic [CNT_W-1:0] x_hi;
  logic [CNT_W-1:0] y_lo;
  logic [CNT_W-1:0] y_hi;
  logic [PIX_W-1:0] fg_cnt;
  logic             ov_hit;

  // armed blocks a rising edge until vsync has been seen low after reset, so
  // a reset released mid-frame never starts a partial frame.
  assign vsync_rise = per_frame_vsync & ~vsync_d & armed;
  assign vsync_fall = ~per_frame_vsync & vsync_d;
  assign href_fall  = ~per_frame_href & href_d;
  assign pix_valid  = (state == ACTIVE) & per_frame_href & per_frame_clken &
                      (col < W_LIM) & (row < H_LIM);
  assign fg         = pix_valid & per_img_Bit;
  assign found_now  = (fg_cnt >= MIN_L);

  // Registered copies of the sync inputs for edge detection and the delayed stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
      clken_d <= 1'b0;
      armed   <= 1'b0;
    end else begin
      vsync_d <= per_frame_vsync;
      href_d  <= per_frame_href;
      clken_d <= per_frame_clken;
      if (!per_frame_vsync) armed <= 1'b1;
    end
  end

  assign post_frame_vsync = vsync_d;
  assign post_frame_href  = href_d;
  assign post_frame_clken = clken_d;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state; a rise during REPORT starts the next frame directly.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (vsync_rise) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (vsync_fall) state_nxt = REPORT;
      end
      REPORT: begin
        if (vsync_rise) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Column/row counters and bounding-box accumulators for the current frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      x_lo   <= CNT_MAX;
      x_hi   <= '0;
      y_lo   <= CNT_MAX;
      y_hi   <= '0;
      fg_cnt <= '0;
    end else if (frame_start) begin
      col    <= '0;
      row    <= '0;
      x_lo   <= CNT_MAX;
      x_hi   <= '0;
      y_lo   <= CNT_MAX;
      y_hi   <= '0;
      fg_cnt <= '0;
    end else if (state == ACTIVE) begin
      if (per_frame_href && per_frame_clken && col != CNT_MAX) col <= col + 1'b1;
      if (href_fall) begin
        col <= '0;
        if (row != CNT_MAX) row <= row + 1'b1;
      end
      if (fg) begin
        if (col < x_lo) x_lo <= col;
        if (col > x_hi) x_hi <= col;
        if (row < y_lo) y_lo <= row;
        if (row > y_hi) y_hi <= row;
        if (fg_cnt != PIX_MAX) fg_cnt <= fg_cnt + 1'b1;
      end
    end
  end

  // Result latch: published in REPORT; an empty frame reports zero bounds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bbox_valid <= 1'b0;
      box_found  <= 1'b0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      pix_cnt    <= '0;
    end else begin
      bbox_valid <= (state == REPORT);
      if (state == REPORT) begin
        box_found <= found_now;
        pix_cnt   <= fg_cnt;
        if (fg_cnt == '0) begin
          x_min <= '0;
          x_max <= '0;
          y_min <= '0;
          y_max <= '0;
        end else begin
          x_min <= x_lo;
          x_max <= x_hi;
          y_min <= y_lo;
          y_max <= y_hi;
        end
      end
    end
  end

`ifdef BBOX_OVERLAY_EN
  logic             ov_valid;
  logic [CNT_W-1:0] ov_x0;
  logic [CNT_W-1:0] ov_x1;
  logic [CNT_W-1:0] ov_y0;
  logic [CNT_W-1:0] ov_y1;

  // Remember the most recent box that met the found threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_valid <= 1'b0;
      ov_x0    <= '0;
      ov_x1    <= '0;
      ov_y0    <= '0;
      ov_y1    <= '0;
    end else if (state == REPORT && found_now) begin
      ov_valid <= 1'b1;
      ov_x0    <= x_lo;
      ov_x1    <= x_hi;
      ov_y0    <= y_lo;
      ov_y1    <= y_hi;
    end
  end

  // Border test against the current pixel position.
  always_comb begin
    ov_hit = 1'b0;
    if (ov_valid && state == ACTIVE && per_frame_href && per_frame_clken) begin
      ov_hit = (((col == ov_x0) || (col == ov_x1)) && (row >= ov_y0) && (row <= ov_y1)) ||
               (((row == ov_y0) || (row == ov_y1)) && (col >= ov_x0) && (col <= ov_x1));
    end
  end
`else
  assign ov_hit = 1'b0;
`endif

  // Delayed bit, forced low outside active lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) post_img_Bit <= 1'b0;
    else     post_img_Bit <= per_frame_href & (per_img_Bit | ov_hit);
  end

endmodule
